pwm_duty_sequencer: RTL and testbench
=====================================

// Module: pwm_duty_sequencer
// PURPOSE
// - Upstream feeder for the PWM core: buffers a stream of compare (duty) samples and
//   presents one on cmp_value_o per PWM period, each held for a programmable repeat count.
// - Paces off the PWM core's period_start pulse, so the core's compare value changes
//   only at period boundaries.
// - Lets a host or pattern source push duty waveforms (fades, tones) without cycle timing.
// PARAMETERS
// - COUNTER_WIDTH  8  width of the duty samples; must match the PWM core
// - FIFO_DEPTH     4  sample buffer entries; power of two, >= 2
// - REPEAT_WIDTH   4  width of repeat_i; each sample is held for repeat_i+1 periods
// PORTS
// - clk             in   1                       system clock, all logic posedge
// - rst             in   1                       synchronous reset, active-high
// - enable_i        in   1                       1 = advance on period_start_i; 0 = freeze output
// - sample_i        in   COUNTER_WIDTH           duty sample to enqueue
// - sample_valid_i  in   1                       sample_i valid
// - sample_ready_o  out  1                       buffer can accept a sample
// - repeat_i        in   REPEAT_WIDTH            hold count, sampled at each pop
// - period_start_i  in   1                       1-cycle pulse from the PWM core's period_start_o
// - cmp_value_o     out  COUNTER_WIDTH           drives the PWM core's cmp_value_i
// - level_o         out  $clog2(FIFO_DEPTH+1)    buffered sample count
// - underflow_o     out  1                       1-cycle pulse: pop was due but buffer was empty
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - FIFO empty; level_o=0; hold_cnt=0; cmp_value_o=0; underflow_o=0.
//   - sample_ready_o=0 while rst is high; it is 1 from the first cycle after reset.
// - Push:
//   - Occurs when sample_valid_i && sample_ready_o.
//   - sample_ready_o = !full, derived from registered level only (no combinational path
//     from period_start_i).
//   - When full, sample_ready_o=0, including in a cycle where a pop also occurs.
//   - The pushing source holds sample_i until it is accepted.
// - Advance: evaluated only when period_start_i && enable_i.
//   - hold_cnt != 0: hold_cnt decrements; cmp_value_o is unchanged.
//   - hold_cnt == 0 and FIFO not empty: pop the head. On the next edge,
//     cmp_value_o <= head and hold_cnt <= repeat_i.
//   - hold_cnt == 0 and FIFO empty: underflow_o=1 for one cycle. cmp_value_o keeps the
//     last value; hold_cnt stays 0, so a pop is attempted again at the next period.
// - Latency:
//   - cmp_value_o changes exactly 1 clk after the period_start_i pulse.
//   - A pushed sample is poppable from the cycle after acceptance. There is no same-cycle
//     bypass: a push and an empty pop in the same cycle produce underflow, and the sample
//     is kept.
// - Simultaneous push and pop (not full):
//   - Both take effect; level_o is unchanged.
//   - FIFO order is preserved.
// - enable_i = 0:
//   - period_start_i is ignored: no pop, no hold_cnt decrement, no underflow.
//   - Pushes are still accepted.
// - Wrap-around: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo
//   FIFO_DEPTH. level_o is held separately in 0..FIFO_DEPTH.
// - Reset mid-operation: buffered samples are discarded, cmp_value_o returns to 0, and any
//   hold in progress is abandoned.
// - All outputs are registered except sample_ready_o, which is a function of registered
//   level only.
// CONFIGURATION
// - PWM_SEQ_UNDERFLOW_CNT_EN defined:
//   - Adds output underflow_cnt_o[7:0]: count of underflow_o pulses, saturating at 255.
//   - Cleared only by rst.
//   - Updates in the same cycle that underflow_o is asserted.
// - Not defined: the port and counter are absent; underflow_o is the only indication.
// TESTING
// - Reset, then push 0x40,0x80 with repeat_i=0 and pulse period_start_i x2:
//   cmp_value_o = 0x40, then 0x80, each 1 clk after its pulse.
// - repeat_i=2, push 0x10, then 0x20, with pulses every 8 clk:
//   0x10 is held for 3 periods; 0x20 appears after the 4th pulse.
// - Empty FIFO with cmp_value_o=0x55, pulse period_start_i:
//   underflow_o=1 for 1 clk; cmp_value_o stays 0x55.
//   With the macro defined, underflow_cnt_o increments to 1.
// - FIFO_DEPTH=4, push 5 samples back-to-back with no pulses:
//   sample_ready_o falls after the 4th push; level_o=4; 5th is accepted after the next pop.
// - enable_i=0 with a full FIFO, 3 pulses:
//   no change to cmp_value_o or level_o. Re-enable: the next pulse pops normally.
// - Assert rst mid-hold (level_o=3, hold_cnt=2):
//   next cycle cmp_value_o=0, level_o=0, no underflow until the next pulse with empty FIFO.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Duty-sample sequencer that feeds the PWM core one compare value per period.
// Buffers samples in a small FIFO and holds each one for repeat_i+1 periods.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   enable_i         1 = advance on period_start_i, 0 = freeze output
//   sample_i         duty sample to enqueue
//   sample_valid_i   sample_i is valid
//   sample_ready_o   buffer can accept a sample (0 while rst is high)
//   repeat_i         hold count, sampled at each pop
//   period_start_i   1-cycle pulse from the PWM core
//   cmp_value_o      compare value for the PWM core
//   level_o          number of buffered samples
//   underflow_o      1-cycle pulse: pop was due but the buffer was empty
//   underflow_cnt_o  saturating underflow count (only with PWM_SEQ_UNDERFLOW_CNT_EN)
//
// Optional feature macro: PWM_SEQ_UNDERFLOW_CNT_EN
module pwm_duty_sequencer #(
    parameter int COUNTER_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable_i,
    input  logic [COUNTER_WIDTH-1:0]         sample_i,
    input  logic                             sample_valid_i,
    output logic                             sample_ready_o,
    input  logic [REPEAT_WIDTH-1:0]          repeat_i,
    input  logic                             period_start_i,
    output logic [COUNTER_WIDTH-1:0]         cmp_value_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o,
    output logic                             underflow_o
`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]                       underflow_cnt_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [COUNTER_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [LVL_W-1:0]         level;
    logic [LVL_W-1:0]         level_nxt;
    logic [REPEAT_WIDTH-1:0]  hold_cnt;

    logic full;
    logic empty;
    logic push;
    logic advance;
    logic hold_zero;
    logic pop;
    logic starve;

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);

    // Ready depends on registered level only; rst gates it so nothing
    // is offered to the source while the block is held in reset.
    assign sample_ready_o = !rst && !full;

    assign push      = sample_valid_i && sample_ready_o;
    assign advance   = period_start_i && enable_i;
    assign hold_zero = (hold_cnt == '0);
    assign pop       = advance && hold_zero && !empty;
    // No bypass: a sample pushed this cycle cannot satisfy this pop.
    assign starve    = advance && hold_zero && empty;

    always_comb begin
        level_nxt = level;
        unique case ({push, pop})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
    end

    // Storage needs no reset; validity is tracked by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            hold_cnt    <= '0;
            cmp_value_o <= '0;
            underflow_o <= 1'b0;
        end else begin
            level       <= level_nxt;
            underflow_o <= starve;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                cmp_value_o <= mem[rd_ptr];
                hold_cnt    <= repeat_i;
            end else if (advance && !hold_zero) begin
                hold_cnt <= hold_cnt - REPEAT_WIDTH'(1);
            end
        end
    end

    assign level_o = level;

`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
    // Counts alongside underflow_o so both change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_cnt_o <= '0;
        end else if (starve && (underflow_cnt_o != 8'hFF)) begin
            underflow_cnt_o <= underflow_cnt_o + 8'd1;
        end
    end
`else
    // Without the counter, underflow_o is the only starvation indication.
`endif

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer.
// Directed scenarios plus random traffic against a queue-based model.
module tb_pwm_duty_sequencer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       enable_i;
    logic [7:0] sample_i;
    logic       sample_valid_i;
    logic       sample_ready_o;
    logic [3:0] repeat_i;
    logic       period_start_i;
    logic [7:0] cmp_value_o;
    logic [2:0] level_o;
    logic       underflow_o;
`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
    logic [7:0] underflow_cnt_o;
`endif

    int checks;
    int failures;

    // Reference model state
    byte unsigned m_q[$];
    logic [7:0]   m_cmp;
    int           m_hold;
    logic         m_uf;
    int           m_ucnt;
    bit           last_push;

    pwm_duty_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .repeat_i       (repeat_i),
        .period_start_i (period_start_i),
        .cmp_value_o    (cmp_value_o),
        .level_o        (level_o),
        .underflow_o    (underflow_o)
`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt_o(underflow_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: model sees the same inputs as the DUT at the edge.
    task automatic cycle();
        bit rdy;
        bit push;
        bit adv;
        rdy  = !rst && (m_q.size() < DEPTH);
        push = sample_valid_i && rdy;
        adv  = period_start_i && enable_i;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_cmp  = 8'h00;
            m_hold = 0;
            m_uf   = 1'b0;
            m_ucnt = 0;
            push   = 1'b0;
        end else begin
            m_uf = 1'b0;
            if (adv) begin
                if (m_hold != 0) begin
                    m_hold--;
                end else if (m_q.size() != 0) begin
                    m_cmp  = m_q.pop_front();
                    m_hold = int'(repeat_i);
                end else begin
                    m_uf = 1'b1;
                    if (m_ucnt < 255) m_ucnt++;
                end
            end
            if (push) m_q.push_back(sample_i);
        end
        last_push = push;
        #1;
    endtask

    task automatic idle_init();
        enable_i       = 1'b1;
        sample_valid_i = 1'b0;
        sample_i       = 8'h00;
        period_start_i = 1'b0;
        repeat_i       = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] v);
        sample_i       = v;
        sample_valid_i = 1'b1;
        cycle();
        sample_valid_i = 1'b0;
    endtask

    task automatic pulse();
        period_start_i = 1'b1;
        cycle();
        period_start_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_init();
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (cmp_value_o !== 8'h00 || level_o !== 3'd0 || underflow_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state cmp=%h lvl=%0d uf=%b required 00/0/0",
                     cmp_value_o, level_o, underflow_o);
        end
        checks++;
        if (sample_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low got %b required 0", sample_ready_o);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (sample_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_high got %b required 1", sample_ready_o);
        end
    endtask

    task automatic test_basic();
        idle_init();
        do_reset();
        push_one(8'h40);
        push_one(8'h80);
        cycle();
        checks++;
        if (level_o !== 3'd2) begin
            failures++;
            $display("FAIL basic_level got %0d required 2", level_o);
        end
        pulse();
        checks++;
        if (cmp_value_o !== 8'h40 || cmp_value_o !== m_cmp) begin
            failures++;
            $display("FAIL basic_first got %h required 40", cmp_value_o);
        end
        cycle();
        cycle();
        checks++;
        if (cmp_value_o !== 8'h40) begin
            failures++;
            $display("FAIL basic_hold got %h required 40", cmp_value_o);
        end
        pulse();
        checks++;
        if (cmp_value_o !== 8'h80 || level_o !== 3'd0) begin
            failures++;
            $display("FAIL basic_second cmp=%h lvl=%0d required 80/0",
                     cmp_value_o, level_o);
        end
    endtask

    task automatic test_repeat();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h10;
        exp_v[1] = 8'h10;
        exp_v[2] = 8'h10;
        exp_v[3] = 8'h20;
        idle_init();
        do_reset();
        repeat_i = 4'd2;
        push_one(8'h10);
        push_one(8'h20);
        for (int p = 0; p < 4; p++) begin
            pulse();
            checks++;
            if (cmp_value_o !== exp_v[p] || cmp_value_o !== m_cmp) begin
                failures++;
                $display("FAIL repeat_pulse%0d got %h required %h",
                         p + 1, cmp_value_o, exp_v[p]);
            end
            repeat (7) cycle();
        end
    endtask

    task automatic test_underflow();
        idle_init();
        do_reset();
        push_one(8'h55);
        pulse();
        cycle();
        pulse();
        checks++;
        if (underflow_o !== 1'b1 || cmp_value_o !== 8'h55) begin
            failures++;
            $display("FAIL underflow_pulse uf=%b cmp=%h required 1/55",
                     underflow_o, cmp_value_o);
        end
`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
        checks++;
        if (underflow_cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL underflow_cnt got %0d required 1", underflow_cnt_o);
        end
`endif
        cycle();
        checks++;
        if (underflow_o !== 1'b0 || cmp_value_o !== 8'h55) begin
            failures++;
            $display("FAIL underflow_clear uf=%b cmp=%h required 0/55",
                     underflow_o, cmp_value_o);
        end
    endtask

    // Leaves the FIFO holding 2,3,4,5 with cmp_value_o=1.
    task automatic test_full();
        idle_init();
        do_reset();
        sample_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sample_i = 8'(i);
            cycle();
        end
        checks++;
        if (level_o !== 3'd4 || sample_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_level lvl=%0d rdy=%b required 4/0",
                     level_o, sample_ready_o);
        end
        sample_i = 8'd5;
        cycle();
        cycle();
        checks++;
        if (level_o !== 3'd4) begin
            failures++;
            $display("FAIL full_blocked lvl=%0d required 4", level_o);
        end
        period_start_i = 1'b1;
        cycle();
        period_start_i = 1'b0;
        checks++;
        if (level_o !== 3'd3 || cmp_value_o !== 8'd1) begin
            failures++;
            $display("FAIL full_pop lvl=%0d cmp=%h required 3/01",
                     level_o, cmp_value_o);
        end
        cycle();
        sample_valid_i = 1'b0;
        checks++;
        if (level_o !== 3'd4 || last_push !== 1'b1) begin
            failures++;
            $display("FAIL full_fifth lvl=%0d required 4", level_o);
        end
    endtask

    task automatic test_disable();
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse();
            cycle();
        end
        checks++;
        if (cmp_value_o !== 8'd1 || level_o !== 3'd4 || underflow_o !== 1'b0) begin
            failures++;
            $display("FAIL disable_frozen cmp=%h lvl=%0d required 01/4",
                     cmp_value_o, level_o);
        end
        enable_i = 1'b1;
        pulse();
        checks++;
        if (cmp_value_o !== 8'd2 || level_o !== 3'd3) begin
            failures++;
            $display("FAIL disable_resume cmp=%h lvl=%0d required 02/3",
                     cmp_value_o, level_o);
        end
    endtask

    task automatic test_reset_mid();
        idle_init();
        do_reset();
        repeat_i = 4'd2;
        for (int i = 0; i < 4; i++) push_one(8'hA0 + 8'(i));
        pulse();
        checks++;
        if (level_o !== 3'd3 || cmp_value_o !== 8'hA0) begin
            failures++;
            $display("FAIL midrst_setup lvl=%0d cmp=%h required 3/a0",
                     level_o, cmp_value_o);
        end
        do_reset();
        checks++;
        if (cmp_value_o !== 8'h00 || level_o !== 3'd0 || underflow_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_cleared cmp=%h lvl=%0d uf=%b required 00/0/0",
                     cmp_value_o, level_o, underflow_o);
        end
        cycle();
        cycle();
        checks++;
        if (underflow_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet uf=%b required 0", underflow_o);
        end
        pulse();
        checks++;
        if (underflow_o !== 1'b1 || cmp_value_o !== 8'h00) begin
            failures++;
            $display("FAIL midrst_underflow uf=%b cmp=%h required 1/00",
                     underflow_o, cmp_value_o);
        end
    endtask

    task automatic test_random();
        idle_init();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (!(sample_valid_i && !last_push)) begin
                sample_valid_i = ($urandom_range(0, 2) != 0);
                sample_i       = 8'($urandom);
            end
            repeat_i       = 4'($urandom_range(0, 3));
            period_start_i = ($urandom_range(0, 3) == 0);
            enable_i       = ($urandom_range(0, 7) != 0);
            rst            = ($urandom_range(0, 99) == 0);
            cycle();
            checks++;
            if (cmp_value_o !== m_cmp || level_o !== 3'(m_q.size())
                || underflow_o !== m_uf) begin
                failures++;
                $display("FAIL random_%0d cmp=%h lvl=%0d uf=%b required %h/%0d/%b",
                         n, cmp_value_o, level_o, underflow_o,
                         m_cmp, m_q.size(), m_uf);
            end
            checks++;
            if (sample_ready_o !== (!rst && m_q.size() < DEPTH)) begin
                failures++;
                $display("FAIL random_ready_%0d got %b", n, sample_ready_o);
            end
`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
            checks++;
            if (underflow_cnt_o !== 8'(m_ucnt)) begin
                failures++;
                $display("FAIL random_ucnt_%0d got %0d required %0d",
                         n, underflow_cnt_o, m_ucnt);
            end
`endif
        end
        rst            = 1'b0;
        sample_valid_i = 1'b0;
        period_start_i = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_push = 1'b0;
        m_cmp     = 8'h00;
        m_hold    = 0;
        m_uf      = 1'b0;
        m_ucnt    = 0;
        rst       = 1'b1;
        idle_init();
        @(negedge clk);
        test_reset();
        test_basic();
        test_repeat();
        test_underflow();
        test_full();
        test_disable();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
